// File: rtl/demux_1_8_reg.sv
// Registered 1-to-8 demultiplexer with per-lane occupancy flags, consumer ACK release and occupancy count.
// Optional broadcast write to all lanes is enabled by defining DEMUX_BCAST_EN.

module demux_1_8_reg_lane #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_wr,
  input  logic             i_ack,
  input  logic [WIDTH-1:0] i_x,
  output logic [WIDTH-1:0] o_a,
  output logic             o_v,
  output logic             o_v_nxt,
  output logic             o_free
);
  logic             r_v;
  logic [WIDTH-1:0] r_a;

  // A write wins over a same-cycle release, so the lane stays occupied with the new word.
  assign o_v_nxt = i_wr | (r_v & ~i_ack);
  assign o_free  = ~r_v | i_ack;
  assign o_v     = r_v;
  assign o_a     = r_a;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v <= 1'b0;
      r_a <= '0;
    end else begin
      r_v <= o_v_nxt;
      if (i_wr) r_a <= i_x;
    end
  end
endmodule

module demux_1_8_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] X,
  input  logic [2:0]       S,
  input  logic             X_valid,
  output logic             X_ready,
  output logic [WIDTH-1:0] A0,
  output logic [WIDTH-1:0] A1,
  output logic [WIDTH-1:0] A2,
  output logic [WIDTH-1:0] A3,
  output logic [WIDTH-1:0] A4,
  output logic [WIDTH-1:0] A5,
  output logic [WIDTH-1:0] A6,
  output logic [WIDTH-1:0] A7,
  output logic [7:0]       V,
  input  logic [7:0]       ACK,
`ifdef DEMUX_BCAST_EN
  input  logic             BCAST,
`endif
  output logic [3:0]       COUNT
);
  localparam int NUM_LANES = 8;

  logic [NUM_LANES-1:0][WIDTH-1:0] w_a;
  logic [NUM_LANES-1:0]            w_v;
  logic [NUM_LANES-1:0]            w_v_nxt;
  logic [NUM_LANES-1:0]            w_free;
  logic [NUM_LANES-1:0]            w_wr;
  logic                            w_bcast;
  logic                            w_accept;
  logic [3:0]                      w_cnt_nxt;
  logic [3:0]                      r_count;

`ifdef DEMUX_BCAST_EN
  assign w_bcast = BCAST;
`else
  assign w_bcast = 1'b0;
`endif

  // Broadcast needs every lane free (or being released) this cycle; S is ignored.
  assign X_ready  = w_bcast ? (&w_free) : w_free[S];
  assign w_accept = X_valid & X_ready;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign w_wr[i] = w_accept & (w_bcast | (S == 3'(i)));

    demux_1_8_reg_lane #(.WIDTH(WIDTH)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .i_wr    (w_wr[i]),
      .i_ack   (ACK[i]),
      .i_x     (X),
      .o_a     (w_a[i]),
      .o_v     (w_v[i]),
      .o_v_nxt (w_v_nxt[i]),
      .o_free  (w_free[i])
    );
  end

  always_comb begin
    w_cnt_nxt = 4'd0;
    for (int i = 0; i < NUM_LANES; i++) w_cnt_nxt = w_cnt_nxt + 4'(w_v_nxt[i]);
  end

  // Count is the popcount of next-state flags, so it tracks V exactly and cannot wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_count <= 4'd0;
    else     r_count <= w_cnt_nxt;
  end

  assign COUNT = r_count;
  assign V     = w_v;
  assign A0    = w_a[0];
  assign A1    = w_a[1];
  assign A2    = w_a[2];
  assign A3    = w_a[3];
  assign A4    = w_a[4];
  assign A5    = w_a[5];
  assign A6    = w_a[6];
  assign A7    = w_a[7];
endmodule

// File: tb/tb_demux_1_8_reg.sv
// Bench for demux_1_8_reg: vector table plus reference model feeding a scoreboard queue.
module tb_demux_1_8_reg;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] X = '0;
  logic [2:0]  S = '0;
  logic        X_valid = 1'b0;
  logic        X_ready;
  logic [15:0] A0, A1, A2, A3, A4, A5, A6, A7;
  logic [7:0]  V;
  logic [7:0]  ACK = '0;
  logic        BCAST = 1'b0;
  logic [3:0]  COUNT;

  demux_1_8_reg #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .X(X), .S(S), .X_valid(X_valid), .X_ready(X_ready),
    .A0(A0), .A1(A1), .A2(A2), .A3(A3), .A4(A4), .A5(A5), .A6(A6), .A7(A7),
    .V(V), .ACK(ACK),
`ifdef DEMUX_BCAST_EN
    .BCAST(BCAST),
`endif
    .COUNT(COUNT)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [2:0]  s;
    logic [15:0] x;
    logic [7:0]  ack;
    logic        exp_ready;
    logic [7:0]  exp_v;
    logic [3:0]  exp_count;
  } vec_t;

  typedef struct {
    string       name;
    logic [7:0]  v;
    logic [3:0]  count;
    logic [15:0] a [8];
  } exp_t;

  exp_t        sb [$];
  logic [15:0] m_a [8];
  logic [7:0]  m_v;
  int          n_checks = 0;
  int          n_errors = 0;

  function automatic logic [15:0] lane(input int i);
    case (i)
      0: return A0; 1: return A1; 2: return A2; 3: return A3;
      4: return A4; 5: return A5; 6: return A6; default: return A7;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] popc(input logic [7:0] v);
    logic [3:0] c = 0;
    for (int i = 0; i < 8; i++) c += 4'(v[i]);
    return c;
  endfunction

  task automatic model_reset();
    m_v = '0;
    for (int i = 0; i < 8; i++) m_a[i] = '0;
  endtask

  // Drive at negedge, check X_ready, push model result, compare after the edge.
  task automatic apply(input string name, input logic valid, input logic [2:0] s, input logic [15:0] x,
                       input logic [7:0] ack, input logic b, input logic exp_ready,
                       input logic [7:0] exp_v, input logic [3:0] exp_count);
    exp_t e;
    logic [7:0] free;
    logic       acc;
    @(negedge clk);
    X_valid = valid; S = s; X = x; ACK = ack; BCAST = b;
    #1;
    chk({name, "_ready"}, X_ready, exp_ready);
    free = ~m_v | ack;
    acc  = valid & (b ? (&free) : free[s]);
    m_v  = m_v & ~ack;
    if (acc) begin
      for (int i = 0; i < 8; i++)
        if (b || s == 3'(i)) begin m_a[i] = x; m_v[i] = 1'b1; end
    end
    e.name = name; e.v = exp_v; e.count = exp_count;
    for (int i = 0; i < 8; i++) e.a[i] = m_a[i];
    chk({name, "_model_v"}, m_v, exp_v);
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({e.name, "_V"}, V, e.v);
    chk({e.name, "_COUNT"}, COUNT, e.count);
    for (int i = 0; i < 8; i++) chk($sformatf("%s_A%0d", e.name, i), lane(i), e.a[i]);
    X_valid = 1'b0; ACK = '0; BCAST = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: timeout reached, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vt [10];
    model_reset();
    //           valid s     x          ack    rdy  v      cnt
    vt[0] = '{1'b1, 3'd5, 16'hA5A5, 8'h00, 1'b1, 8'h20, 4'd1};
    vt[1] = '{1'b1, 3'd3, 16'h1111, 8'h00, 1'b1, 8'h28, 4'd2};
    vt[2] = '{1'b1, 3'd3, 16'h2222, 8'h00, 1'b0, 8'h28, 4'd2};
    vt[3] = '{1'b1, 3'd3, 16'h3333, 8'h08, 1'b1, 8'h28, 4'd2};
    vt[4] = '{1'b1, 3'd0, 16'h6666, 8'h20, 1'b1, 8'h09, 4'd2};
    vt[5] = '{1'b0, 3'd0, 16'h0000, 8'hFF, 1'b1, 8'h00, 4'd0};
    vt[6] = '{1'b1, 3'd2, 16'h4444, 8'h40, 1'b1, 8'h04, 4'd1};
    vt[7] = '{1'b1, 3'd2, 16'h5555, 8'h04, 1'b1, 8'h04, 4'd1};
    vt[8] = '{1'b0, 3'd2, 16'h0000, 8'h04, 1'b1, 8'h00, 4'd0};
    vt[9] = '{1'b0, 3'd2, 16'h7777, 8'h00, 1'b1, 8'h00, 4'd0};

    #1;
    chk("rst_V", V, 8'h00);
    chk("rst_COUNT", COUNT, 4'd0);
    chk("rst_ready", X_ready, 1'b1);
    for (int i = 0; i < 8; i++) chk($sformatf("rst_A%0d", i), lane(i), 16'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 10; k++)
      apply($sformatf("vec%0d", k), vt[k].valid, vt[k].s, vt[k].x, vt[k].ack, 1'b0,
            vt[k].exp_ready, vt[k].exp_v, vt[k].exp_count);

    // Fill every lane, then release all in one cycle.
    for (int i = 0; i < 8; i++)
      apply($sformatf("fill%0d", i), 1'b1, 3'(i), 16'(i), 8'h00, 1'b0, 1'b1,
            8'((16'h1 << (i + 1)) - 1), 4'(i + 1));
    apply("full_busy", 1'b1, 3'd6, 16'hDEAD, 8'h00, 1'b0, 1'b0, 8'hFF, 4'd8);
    apply("ack_all", 1'b0, 3'd0, 16'h0, 8'hFF, 1'b0, 1'b1, 8'h00, 4'd0);

    // Asynchronous reset between edges with lanes 0..3 occupied.
    for (int i = 0; i < 4; i++)
      apply($sformatf("pre%0d", i), 1'b1, 3'(i), 16'hC000 | 16'(i), 8'h00, 1'b0, 1'b1,
            8'((16'h1 << (i + 1)) - 1), popc(8'((16'h1 << (i + 1)) - 1)));
    @(negedge clk);
    #2;
    X_valid = 1'b1; S = 3'd4; X = 16'hBEEF;
    rst = 1'b1;
    #1;
    chk("arst_V", V, 8'h00);
    chk("arst_COUNT", COUNT, 4'd0);
    chk("arst_ready", X_ready, 1'b1);
    for (int i = 0; i < 8; i++) chk($sformatf("arst_A%0d", i), lane(i), 16'h0);
    @(posedge clk);
    #1;
    chk("arst_hold_V", V, 8'h00);
    chk("arst_hold_A4", A4, 16'h0);
    @(negedge clk);
    rst = 1'b0; X_valid = 1'b0;
    model_reset();
    apply("post_rst", 1'b1, 3'd7, 16'h0F0F, 8'h00, 1'b0, 1'b1, 8'h80, 4'd1);

`ifdef DEMUX_BCAST_EN
    apply("bc_ack_prev", 1'b1, 3'd0, 16'h0001, 8'h80, 1'b0, 1'b1, 8'h01, 4'd1);
    apply("bc_blocked", 1'b1, 3'd5, 16'h1234, 8'h00, 1'b1, 1'b0, 8'h01, 4'd1);
    apply("bc_go", 1'b1, 3'd5, 16'h1234, 8'h01, 1'b1, 1'b1, 8'hFF, 4'd8);
`endif

    if (sb.size() != 0) chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
